regfile_wport_arb_async_rstn: RTL and testbench
===============================================

// Module: regfile_wport_arb_async_rstn
// PURPOSE
//  Shares one register-file write port among N_REQ requesters with fair round-robin arbitration.
//  Sits in front of a regfile write port: waddr[0] / wen[0] / wdata[0].
//  Each requester uses a valid/ready handshake. The winning write is registered for one cycle
//  before it is driven onto the regfile port. A hold input lets a sequencer freeze writes.
// PARAMETERS
//  WIDTH  32  data width of each register
//  N_REG  32  number of registers; AW = $clog2(N_REG), minimum 1
//  N_REQ  4   number of requesters, 2..16
// PORTS
//  clk        in   1            single clock
//  rstn       in   1            asynchronous active-low reset
//  req_valid  in   N_REQ        per-requester write request
//  req_addr   in   N_REQ x AW   per-requester target register
//  req_data   in   N_REQ x WIDTH  per-requester write data
//  req_ready  out  N_REQ        one-hot grant; a write is accepted when valid & ready
//  hold       in   1            sequencer pause; no grants while high
//  rf_wen     out  1            regfile write enable (registered)
//  rf_waddr   out  AW           regfile write address (registered)
//  rf_wdata   out  WIDTH        regfile write data (registered)
//  gnt_id     out  $clog2(N_REQ)  index of the requester whose write is on rf_* (registered)
//  busy       out  1            FSM not in IDLE, or rf_wen high
// BEHAVIOUR
//  Reset (async, rstn=0): all outputs 0, pointer=0, state=IDLE. An in-flight write is dropped, never replayed.
//  FSM:
//   - IDLE->ARB when any req_valid & !hold.
//   - ARB->PAUSE when hold.
//   - ARB->IDLE when no valid.
//   - PAUSE->ARB when !hold & any valid; PAUSE->IDLE when !hold & none valid.
//  Grant (ARB, !hold only):
//   - Search from ptr upward, with wrap, for the first valid requester k; req_ready = onehot(k), same cycle.
//   - req_ready is combinational from req_valid/ptr/state/hold.
//   - req_ready is never high for a non-valid requester, and at most 1 bit is high.
//  On accept: next cycle rf_wen=1, rf_waddr=req_addr[k], rf_wdata=req_data[k], gnt_id=k; ptr <= (k+1) mod N_REQ.
//  Otherwise rf_wen=0 next cycle; rf_waddr/rf_wdata/gnt_id hold their last values.
//  Latency: accept to rf_wen = 1 cycle. Throughput: 1 write per cycle; back-to-back grants allowed.
//  hold rising: no grant in that cycle. An already-registered write still issues (drains) in the next cycle.
//  Fairness: a requester that stays valid is granted within N_REQ accepts.
//  Address >= N_REG: forwarded unchanged; decode is the regfile's job.
//  Simultaneous valid from all requesters with ptr=N_REQ-1: requester N_REQ-1 wins, then ptr wraps to 0.
//  Requester dropping valid without ready: legal, no state change.
// CONFIGURATION
//  Macro REGFILE_WARB_SAME_ADDR_EN:
//   - Defined: adds output port coll_err (1b, registered, reset 0). coll_err pulses 1 for one cycle when,
//     in an accept cycle, another valid non-granted requester targets the same req_addr as the winner.
//   - coll_err is a debug flag only; arbitration is unchanged.
//  Undefined: port and logic absent; everything else identical.
// STRUCTURE
//  Package regfile_pkg:
//   - typedef enum logic [1:0] {ARB_IDLE, ARB_ACTIVE, ARB_PAUSE} warb_state_e;
//   - localparam function warb_aw(n) = (n>1) ? $clog2(n) : 1.
//  Sub-module rr_pick: combinational.
//   - Inputs: req vector, ptr.
//   - Outputs: onehot grant, encoded index, any.
//   - Implemented with a double-width masked priority search.
//  Top level holds the FSM, ptr, output pipeline register and the optional collision flag.
// TESTING
//  1 Reset: rstn=0 mid-stream with rf_wen=1 -> all outputs 0 immediately. After release: ptr=0, state=IDLE.
//  2 Single: req_valid=4'b0100, addr=5, data=32'hDEADBEEF -> req_ready=4'b0100 same cycle.
//     Next cycle rf_wen=1, rf_waddr=5, rf_wdata=DEADBEEF, gnt_id=2.
//  3 Round-robin: req_valid=4'b1111 held 8 cycles -> grant order 0,1,2,3,0,1,2,3. rf_wen=1 every cycle from cycle 1.
//  4 Hold: hold=1 after the grant to requester 1 -> next cycle that write still issues, req_ready=0.
//     On release, requester 2 is granted first.
//  5 Wrap: ptr=3, valid=4'b1001 -> requester 3 granted, then requester 0.
//  6 Collision (macro on): req 0 and req 2 both addr=7, ptr=0 -> requester 0 granted, coll_err=1 next cycle only.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and helpers for the regfile write-port arbiter
package regfile_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ACTIVE, ARB_PAUSE} warb_state_e;

    function automatic int warb_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wport_arb_async_rstn_rr_pick.sv
// rr_pick: combinational round-robin picker, first set bit of req at or above ptr, with wrap
//   req  in   N        request vector
//   ptr  in   IW       search start position
//   gnt  out  N        one-hot winner
//   idx  out  IW       encoded winner
//   any  out  1        at least one request
module rr_pick
    import regfile_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = warb_aw(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Lower half holds requests at or above ptr, upper half the unmasked copy for wrap-around.
    logic [2*N-1:0] dbl;
    int pos;

    assign dbl = {req, req & ({N{1'b1}} << ptr)};
    assign any = |req;

    always_comb begin
        pos = 0;
        for (int i = 2*N-1; i >= 0; i--)
            if (dbl[i]) pos = i;
        idx = IW'(pos >= N ? pos - N : pos);
        gnt = any ? N'(1) << idx : '0;
    end

endmodule

// File: rtl/regfile_wport_arb_async_rstn.sv
// regfile_wport_arb_async_rstn: round-robin arbiter sharing one registered regfile write port
//   clk, rstn                 clock, asynchronous active-low reset
//   req_valid/addr/data  in   per-requester write requests
//   req_ready            out  one-hot combinational grant
//   hold                 in   freezes new grants
//   rf_wen/waddr/wdata   out  registered regfile write port
//   gnt_id               out  requester owning the write on rf_*
//   busy                 out  FSM not idle or write in flight
//   coll_err             out  only with REGFILE_WARB_SAME_ADDR_EN: winner address also requested by a loser
module regfile_wport_arb_async_rstn
    import regfile_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_REG = 32,
    parameter int N_REQ = 4,
    localparam int AW = warb_aw(N_REG),
    localparam int IW = warb_aw(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0][AW-1:0]    req_addr,
    input  logic [N_REQ-1:0][WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        hold,
    output logic                        rf_wen,
    output logic [AW-1:0]               rf_waddr,
    output logic [WIDTH-1:0]            rf_wdata,
    output logic [IW-1:0]               gnt_id,
    output logic                        busy
`ifdef REGFILE_WARB_SAME_ADDR_EN
    ,
    output logic                        coll_err
`endif
);

    warb_state_e      state;
    logic [IW-1:0]    ptr, idx;
    logic [N_REQ-1:0] gnt;
    logic             any, acc;

    rr_pick #(.N(N_REQ)) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (idx),
        .any (any)
    );

    assign req_ready = (state == ARB_ACTIVE && !hold) ? gnt : '0;
    assign acc       = |(req_valid & req_ready);
    assign busy      = state != ARB_IDLE || rf_wen;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ARB_IDLE;
            ptr      <= '0;
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            gnt_id   <= '0;
        end else begin
            rf_wen <= acc;
            if (acc) begin
                rf_waddr <= req_addr[idx];
                rf_wdata <= req_data[idx];
                gnt_id   <= idx;
                ptr      <= (idx == IW'(N_REQ-1)) ? '0 : idx + 1'b1;
            end
            // ARB and PAUSE share the same exits; IDLE ignores hold.
            state <= (state == ARB_IDLE && hold) ? ARB_IDLE :
                     hold ? ARB_PAUSE :
                     any  ? ARB_ACTIVE : ARB_IDLE;
        end
    end

`ifdef REGFILE_WARB_SAME_ADDR_EN
    logic [N_REQ-1:0] same;

    always_comb begin
        same = '0;
        for (int j = 0; j < N_REQ; j++)
            same[j] = req_valid[j] && !gnt[j] && req_addr[j] == req_addr[idx];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) coll_err <= 1'b0;
        else       coll_err <= acc && |same;
    end
`endif

endmodule

// File: tb/tb_regfile_wport_arb_async_rstn.sv
// tb_regfile_wport_arb_async_rstn: scoreboard bench for the regfile write-port arbiter
module tb_regfile_wport_arb_async_rstn;
    import regfile_pkg::*;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int AW = 5;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic                   hold = 1'b0;
    logic [N-1:0]           req_valid = '0;
    logic [N-1:0]           req_ready;
    logic [N-1:0][AW-1:0]   req_addr = '0;
    logic [N-1:0][W-1:0]    req_data = '0;
    logic                   rf_wen;
    logic [AW-1:0]          rf_waddr;
    logic [W-1:0]           rf_wdata;
    logic [1:0]             gnt_id;
    logic                   busy;
`ifdef REGFILE_WARB_SAME_ADDR_EN
    logic                   coll_err;
`endif

    typedef struct packed {
        logic [AW-1:0] a;
        logic [W-1:0]  d;
        logic [1:0]    id;
        logic          c;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   m_state = 0;
    int   m_ptr = 0;

    always #5 clk = ~clk;

    regfile_wport_arb_async_rstn #(.WIDTH(W), .N_REG(32), .N_REQ(N)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .hold      (hold),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .gnt_id    (gnt_id),
        .busy      (busy)
`ifdef REGFILE_WARB_SAME_ADDR_EN
        ,
        .coll_err  (coll_err)
`endif
    );

    // One clock: check the combinational grant against the model, score the accept,
    // advance the model, then compare the registered write port with the scoreboard.
    task automatic step(input string tag);
        logic [N-1:0] exp_rdy;
        int           k;
        exp_t         e;
        logic         ew;
        exp_rdy = '0;
        k = 0;
        #1;
        if (m_state == 1 && !hold && |req_valid) begin
            for (int i = 0; i < N; i++)
                if (req_valid[(m_ptr + i) % N]) begin
                    k = (m_ptr + i) % N;
                    break;
                end
            exp_rdy[k] = 1'b1;
        end
        checks++;
        if (req_ready !== exp_rdy) begin
            failures++;
            $display("FAIL %s ready: got %b want %b", tag, req_ready, exp_rdy);
        end
        if (|exp_rdy) begin
            e.a  = req_addr[k];
            e.d  = req_data[k];
            e.id = 2'(k);
            e.c  = 1'b0;
            for (int j = 0; j < N; j++)
                if (j != k && req_valid[j] && req_addr[j] == req_addr[k]) e.c = 1'b1;
            q.push_back(e);
            m_ptr = (k + 1) % N;
        end
        m_state = (m_state == 0 && hold) ? 0 : hold ? 2 : (|req_valid) ? 1 : 0;
        @(posedge clk);
        #1;
        ew = q.size() > 0;
        checks++;
        if (rf_wen !== ew) begin
            failures++;
            $display("FAIL %s rf_wen: got %b want %b", tag, rf_wen, ew);
        end
        if (ew) begin
            e = q.pop_front();
            checks++;
            if (rf_waddr !== e.a || rf_wdata !== e.d || gnt_id !== e.id) begin
                failures++;
                $display("FAIL %s write: got a=%0d d=%h id=%0d want a=%0d d=%h id=%0d",
                         tag, rf_waddr, rf_wdata, gnt_id, e.a, e.d, e.id);
            end
        end
`ifdef REGFILE_WARB_SAME_ADDR_EN
        checks++;
        if (coll_err !== (ew && e.c)) begin
            failures++;
            $display("FAIL %s coll_err: got %b want %b", tag, coll_err, ew && e.c);
        end
`endif
        checks++;
        if (busy !== (m_state != 0 || ew)) begin
            failures++;
            $display("FAIL %s busy: got %b want %b", tag, busy, m_state != 0 || ew);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        rstn = 1'b1;
        m_state = 0;
        m_ptr = 0;
        q.delete();
        hold = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (rf_wen !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0 || gnt_id !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_init: got wen=%b a=%0d d=%h id=%0d busy=%b want all 0",
                     rf_wen, rf_waddr, rf_wdata, gnt_id, busy);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_addr[i] = AW'(i + 20);
            req_data[i] = $urandom;
        end
        req_valid = 4'b1111;
        step("reset_pre0");
        step("reset_pre1");
        // A write is now on rf_*; an async reset must clear it without waiting for a clock.
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if (rf_wen !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0 || gnt_id !== '0 || busy !== 1'b0 || req_ready !== '0) begin
            failures++;
            $display("FAIL reset_async: got wen=%b a=%0d d=%h id=%0d busy=%b rdy=%b want all 0",
                     rf_wen, rf_waddr, rf_wdata, gnt_id, busy, req_ready);
        end
        do_reset();
        step("reset_idle");
    endtask

    task automatic test_single();
        do_reset();
        req_addr[2] = 5'd5;
        req_data[2] = 32'hDEADBEEF;
        req_valid = 4'b0100;
        step("single_arb");
        step("single_grant");
        req_valid = '0;
        step("single_drop");
        step("single_idle");
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = 4'b1111;
        for (int c = 0; c < 9; c++) begin
            for (int i = 0; i < N; i++) begin
                req_addr[i] = AW'($urandom);
                req_data[i] = $urandom;
            end
            step("rr");
        end
        req_valid = '0;
        step("rr_end");
    endtask

    task automatic test_hold();
        do_reset();
        req_valid = 4'b0110;
        req_data[1] = 32'h1111_0001;
        req_data[2] = 32'h2222_0002;
        step("hold_arb");
        step("hold_grant1");
        hold = 1'b1;
        step("hold_drain");
        step("hold_pause");
        hold = 1'b0;
        step("hold_release");
        step("hold_grant2");
        req_valid = '0;
        step("hold_end");
        step("hold_idle");
    endtask

    task automatic test_wrap();
        do_reset();
        req_valid = 4'b0100;
        step("wrap_arb");
        step("wrap_ptr3");
        req_valid = 4'b1001;
        req_data[3] = 32'h3333_0003;
        req_data[0] = 32'h0000_AAAA;
        step("wrap_g3");
        step("wrap_g0");
        req_valid = 4'b0001;
        step("wrap_drop");
        req_valid = '0;
        step("wrap_end");
        step("wrap_idle");
    endtask

    task automatic test_collision();
        do_reset();
        req_addr[0] = 5'd7;
        req_addr[2] = 5'd7;
        req_data[0] = 32'hC0C0_0000;
        req_data[2] = 32'hC0C0_0002;
        req_valid = 4'b0101;
        step("coll_arb");
        step("coll_grant0");
        req_valid = '0;
        step("coll_clear");
        step("coll_idle");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_wrap();
        test_collision();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
